uartbytes_to_bram: RTL and testbench
====================================

// Module: uartbytes_to_bram
// PURPOSE
//  UART-to-BRAM loader: the inbound counterpart of the BRAM-to-UART readout. Receives
//  8N1 serial bytes, packs BRAM_WIDTH/8 bytes per word (first byte -> MSBs) and writes
//  words to consecutive BRAM addresses 0..BRAM_DEPTH-1 via a write port.
//  Sits between the FPGA top-level UART RX pin and port A of a dual-port BRAM.
// PARAMETERS
//  BRAM_WIDTH  24                bits per BRAM entry; multiple of 8, >= 8
//  BRAM_DEPTH  320*240           number of entries to fill
//  BAUD_RATE   3000000           serial bit rate (bits/s)
//  CLK_FREQ    100000000         clk_in frequency (Hz); CLK_PER_BAUD=CLK_FREQ/BAUD_RATE >= 4
// PORTS
//  clk_in             in   1                     clock
//  rst_n_in           in   1                     async active-low reset
//  receive_enable_in  in   1                     1 = accept bytes; 0 = hold cleared (sync clear)
//  uart_rx            in   1                     asynchronous serial input, idle high
//  write_index_out    out  $clog2(BRAM_DEPTH)    BRAM write address
//  write_data_out     out  BRAM_WIDTH            BRAM write data
//  write_enable_out   out  1                     1-cycle write strobe
//  done_out           out  1                     all BRAM_DEPTH entries written (level)
//  frame_error_out    out  1                     sticky: a stop bit sampled low
// BEHAVIOUR
//  Reset (rst_n_in=0, async): all outputs 0; sync flops = 1; RX FSM IDLE; byte/baud counters 0.
//  uart_rx passes a 2-flop synchronizer (reset value 1); all sampling uses the synced value.
//  RX FSM (baud counter counts 0..CLK_PER_BAUD-1):
//   IDLE : synced rx == 0 -> START, baud counter = 0.
//   START: at count CLK_PER_BAUD/2: rx==0 -> DATA (counter reset, bit idx 0); rx==1 -> IDLE (glitch).
//   DATA : every CLK_PER_BAUD clocks sample one bit, LSB first; after bit 7 -> STOP.
//   STOP : after CLK_PER_BAUD clocks sample: 1 -> byte accepted; 0 -> byte dropped,
//          frame_error_out <= 1. Either way -> IDLE next cycle.
//  Packing: shift register + byte counter 0..BRAM_WIDTH/8-1. Accepted byte shifts in at LSB end.
//   On the last byte of a word: write_data_out <= {shift[W-9:0], byte}, write_enable_out = 1
//   for exactly the cycle after the stop-bit sample edge; write_index_out is stable and
//   valid during that cycle; byte counter -> 0.
//   write_index_out increments on the edge ending the strobe; after writing index
//   BRAM_DEPTH-1 it holds at BRAM_DEPTH-1 and done_out <= 1 on that same edge.
//  done_out = 1: further bytes are received (FSM runs) but ignored; no strobes; index unchanged.
//  Dropped (framing-error) byte: byte counter and shift register unchanged.
//  write_data_out holds last written word between strobes.
//  receive_enable_in = 0: synchronously clears index, byte counter, shift reg, done_out,
//   frame_error_out, write_enable_out; forces RX FSM IDLE. On re-enable reception restarts
//   at index 0, first falling edge seen is a start bit (host starts sending only with line idle).
//  rst_n_in low mid-frame: immediate clear as above; partial byte/word discarded.
//  Width rules: baud counter $clog2(CLK_PER_BAUD) bits; byte counter $clog2(BRAM_WIDTH/8)+1 bits.
// TESTING (CLK_FREQ=100000000, BAUD_RATE=25000000 -> CLK_PER_BAUD=4, BRAM_WIDTH=24)
//  1 Reset: drive rst_n_in=0 mid-byte -> all outputs 0 at once; after release, next clean
//    frame bytes 0x11,0x22,0x33 -> one write, data 0x112233, index 0.
//  2 Single word: enable=1, send 0xAB,0xCD,0xEF -> exactly one write_enable_out pulse,
//    write_data_out=0xABCDEF, write_index_out=0 during pulse, 1 afterwards.
//  3 Fill (BRAM_DEPTH=4): 12 bytes 0x00..0x0B -> writes 0x000102@0,0x030405@1,
//    0x060708@2,0x090A0B@3; done_out=1 after last; 13th byte -> no strobe, index stays 3.
//  4 Framing error: send 0x55 with stop bit 0 -> frame_error_out=1, no byte counted; then
//    0x01,0x02,0x03 -> write 0x010203 at index 0; frame_error_out stays 1.
//  5 Glitch: uart_rx low 1 clk then high -> no byte accepted, FSM back in IDLE, no strobe.
//  6 Enable drop: 2 bytes sent, receive_enable_in=0 for 2 clk, then 0xA1,0xB2,0xC3 ->
//    write 0xA1B2C3 at index 0 (partial word discarded), frame_error_out/done_out cleared.

Source files
------------

// File: rtl/uartbytes_to_bram.sv
// uartbytes_to_bram: receives 8N1 serial bytes, packs BRAM_WIDTH/8 bytes per word
// (first byte lands in the MSBs) and writes each word to consecutive BRAM addresses
// 0..BRAM_DEPTH-1 through a single-cycle write strobe.
//
// Ports:
//   clk_in             clock
//   rst_n_in           asynchronous active-low reset
//   receive_enable_in  1 = accept bytes; 0 = hold loader cleared (synchronous)
//   uart_rx            asynchronous serial input, idle high
//   write_index_out    BRAM write address, valid while write_enable_out is high
//   write_data_out     BRAM write data, holds the last written word between strobes
//   write_enable_out   one-cycle write strobe
//   done_out           level: all BRAM_DEPTH entries have been written
//   frame_error_out    sticky: a stop bit was sampled low
module uartbytes_to_bram #(
    parameter int unsigned BRAM_WIDTH = 24,
    parameter int unsigned BRAM_DEPTH = 320 * 240,
    parameter int unsigned BAUD_RATE  = 3000000,
    parameter int unsigned CLK_FREQ   = 100000000
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          receive_enable_in,
    input  logic                          uart_rx,
    output logic [$clog2(BRAM_DEPTH)-1:0] write_index_out,
    output logic [BRAM_WIDTH-1:0]         write_data_out,
    output logic                          write_enable_out,
    output logic                          done_out,
    output logic                          frame_error_out
);

    localparam int unsigned CLK_PER_BAUD = CLK_FREQ / BAUD_RATE;
    localparam int unsigned BAUD_W       = $clog2(CLK_PER_BAUD);
    localparam int unsigned BYTES        = BRAM_WIDTH / 8;
    localparam int unsigned BCNT_W       = $clog2(BYTES) + 1;
    localparam int unsigned IDX_W        = $clog2(BRAM_DEPTH);

    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLK_PER_BAUD / 2);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BAUD - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BYTES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(BRAM_DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;

    rx_state_e           state_q;
    logic                rx_meta_q;
    logic                rx_sync_q;
    logic [BAUD_W-1:0]   baud_cnt_q;
    logic [2:0]          bit_idx_q;
    logic [7:0]          rx_byte_q;
    logic [BCNT_W-1:0]   byte_cnt_q;
    logic [BRAM_WIDTH-1:0] shift_q;

    // Word formed by appending the byte currently held in rx_byte_q; older bytes move
    // toward the MSBs, so the first byte of a word ends up on top.
    logic [BRAM_WIDTH-1:0] packed_word;
    assign packed_word = (shift_q << 8) | BRAM_WIDTH'(rx_byte_q);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q          <= StIdle;
            rx_meta_q        <= 1'b1;
            rx_sync_q        <= 1'b1;
            baud_cnt_q       <= '0;
            bit_idx_q        <= '0;
            rx_byte_q        <= '0;
            byte_cnt_q       <= '0;
            shift_q          <= '0;
            write_index_out  <= '0;
            write_data_out   <= '0;
            write_enable_out <= 1'b0;
            done_out         <= 1'b0;
            frame_error_out  <= 1'b0;
        end else begin
            rx_meta_q <= uart_rx;
            rx_sync_q <= rx_meta_q;

            if (!receive_enable_in) begin
                state_q          <= StIdle;
                baud_cnt_q       <= '0;
                bit_idx_q        <= '0;
                byte_cnt_q       <= '0;
                shift_q          <= '0;
                write_index_out  <= '0;
                write_enable_out <= 1'b0;
                done_out         <= 1'b0;
                frame_error_out  <= 1'b0;
            end else begin
                // Edge that ends the strobe advances the address, or latches done on the
                // final entry so the index parks at BRAM_DEPTH-1.
                if (write_enable_out) begin
                    write_enable_out <= 1'b0;
                    if (write_index_out == IDX_LAST) begin
                        done_out <= 1'b1;
                    end else begin
                        write_index_out <= write_index_out + IDX_W'(1);
                    end
                end

                unique case (state_q)
                    StIdle: begin
                        if (!rx_sync_q) begin
                            state_q    <= StStart;
                            baud_cnt_q <= '0;
                        end
                    end
                    StStart: begin
                        if (baud_cnt_q == BAUD_HALF) begin
                            baud_cnt_q <= '0;
                            bit_idx_q  <= '0;
                            // Line back high at mid-start means it was only a glitch.
                            state_q    <= rx_sync_q ? StIdle : StData;
                        end else begin
                            baud_cnt_q <= baud_cnt_q + BAUD_W'(1);
                        end
                    end
                    StData: begin
                        if (baud_cnt_q == BAUD_LAST) begin
                            baud_cnt_q <= '0;
                            rx_byte_q  <= {rx_sync_q, rx_byte_q[7:1]};
                            if (bit_idx_q == 3'd7) begin
                                state_q <= StStop;
                            end else begin
                                bit_idx_q <= bit_idx_q + 3'd1;
                            end
                        end else begin
                            baud_cnt_q <= baud_cnt_q + BAUD_W'(1);
                        end
                    end
                    StStop: begin
                        if (baud_cnt_q == BAUD_LAST) begin
                            baud_cnt_q <= '0;
                            state_q    <= StIdle;
                            if (!rx_sync_q) begin
                                // Dropped byte: packing state is left untouched.
                                frame_error_out <= 1'b1;
                            end else if (!done_out) begin
                                shift_q <= packed_word;
                                if (byte_cnt_q == BCNT_LAST) begin
                                    byte_cnt_q       <= '0;
                                    write_data_out   <= packed_word;
                                    write_enable_out <= 1'b1;
                                end else begin
                                    byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
                                end
                            end
                        end else begin
                            baud_cnt_q <= baud_cnt_q + BAUD_W'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uartbytes_to_bram.sv
module tb_uartbytes_to_bram;

    localparam int unsigned CPB = 4;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        receive_enable_in;
    logic        uart_rx;
    logic [1:0]  write_index_out;
    logic [23:0] write_data_out;
    logic        write_enable_out;
    logic        done_out;
    logic        frame_error_out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0]  idx;
        logic [23:0] data;
    } exp_t;

    exp_t exp_q[$];

    uartbytes_to_bram #(
        .BRAM_WIDTH(24),
        .BRAM_DEPTH(4),
        .BAUD_RATE (25000000),
        .CLK_FREQ  (100000000)
    ) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .receive_enable_in(receive_enable_in),
        .uart_rx          (uart_rx),
        .write_index_out  (write_index_out),
        .write_data_out   (write_data_out),
        .write_enable_out (write_enable_out),
        .done_out         (done_out),
        .frame_error_out  (frame_error_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_write(input logic [1:0] idx, input logic [23:0] data);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Pops one expected write per strobe cycle, sampled on the falling edge.
    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (write_enable_out) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got idx %0d data 0x%06h, expected no write",
                             write_index_out, write_data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("write_data", 32'(write_data_out), 32'(e.data));
                    check("write_index", 32'(write_index_out), 32'(e.idx));
                end
            end
        end
    endtask

    task automatic send_bit(input logic v);
        uart_rx = v;
        repeat (CPB) @(negedge clk_in);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    task automatic drop_enable();
        receive_enable_in = 1'b0;
        repeat (2) @(negedge clk_in);
        receive_enable_in = 1'b1;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_index"}, 32'(write_index_out), 32'd0);
        check({tag, "_data"}, 32'(write_data_out), 32'd0);
        check({tag, "_we"}, 32'(write_enable_out), 32'd0);
        check({tag, "_done"}, 32'(done_out), 32'd0);
        check({tag, "_ferr"}, 32'(frame_error_out), 32'd0);
    endtask

    initial begin
        rst_n_in          = 1'b0;
        receive_enable_in = 1'b0;
        uart_rx           = 1'b1;
        fork
            monitor_loop();
        join_none

        repeat (3) @(negedge clk_in);
        check_all_zero("reset");
        rst_n_in          = 1'b1;
        receive_enable_in = 1'b1;
        repeat (4) @(negedge clk_in);

        // Single word
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        expect_write(2'd0, 24'hABCDEF);
        send_byte(8'hEF, 1'b1);
        check("index_after_word", 32'(write_index_out), 32'd1);
        check("data_held", 32'(write_data_out), 32'hABCDEF);

        // Reset in the middle of a byte
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst_n_in = 1'b0;
        #1;
        check_all_zero("midbyte_reset");
        uart_rx = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        repeat (4) @(negedge clk_in);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        expect_write(2'd0, 24'h112233);
        send_byte(8'h33, 1'b1);

        // Partial word discarded by enable drop, then framing error
        send_byte(8'h77, 1'b1);
        send_byte(8'h88, 1'b1);
        drop_enable();
        check("ferr_before_bad_stop", 32'(frame_error_out), 32'd0);
        check("index_after_drop1", 32'(write_index_out), 32'd0);
        send_byte(8'h55, 1'b0);
        check("ferr_set", 32'(frame_error_out), 32'd1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        expect_write(2'd0, 24'h010203);
        send_byte(8'h03, 1'b1);
        check("ferr_sticky", 32'(frame_error_out), 32'd1);

        // One-clock glitch between bytes of a word
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b1);
        uart_rx = 1'b0;
        @(negedge clk_in);
        uart_rx = 1'b1;
        repeat (12) @(negedge clk_in);
        expect_write(2'd1, 24'h102030);
        send_byte(8'h30, 1'b1);
        check("index_after_glitch", 32'(write_index_out), 32'd2);

        // Fill all four entries, with a dropped byte inside the second word
        drop_enable();
        check("ferr_cleared_by_enable", 32'(frame_error_out), 32'd0);
        check("index_before_fill", 32'(write_index_out), 32'd0);
        expect_write(2'd0, 24'h000102);
        expect_write(2'd1, 24'h030405);
        expect_write(2'd2, 24'h060708);
        expect_write(2'd3, 24'h090A0B);
        for (int i = 0; i < 12; i++) begin
            if (i == 5) send_byte(8'hEE, 1'b0);
            send_byte(8'(i), 1'b1);
        end
        check("done_after_fill", 32'(done_out), 32'd1);
        check("index_after_fill", 32'(write_index_out), 32'd3);
        check("ferr_during_fill", 32'(frame_error_out), 32'd1);
        send_byte(8'h0C, 1'b1);
        check("index_held_when_done", 32'(write_index_out), 32'd3);
        check("done_held", 32'(done_out), 32'd1);

        // Enable drop clears done/frame error and restarts at index 0
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        drop_enable();
        check("done_cleared", 32'(done_out), 32'd0);
        check("ferr_cleared", 32'(frame_error_out), 32'd0);
        check("index_cleared", 32'(write_index_out), 32'd0);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hB2, 1'b1);
        expect_write(2'd0, 24'hA1B2C3);
        send_byte(8'hC3, 1'b1);
        check("index_after_restart", 32'(write_index_out), 32'd1);
        check("done_after_restart", 32'(done_out), 32'd0);

        repeat (20) @(negedge clk_in);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
